// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and the baud divider calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_state_e;

    // Clocks per oversample tick, floored, never below 1.
    function automatic int calc_div(input int clk_freq, input int baud_rate, input int oversample);
        int div;
        div = clk_freq / (baud_rate * oversample);
        return (div < 1) ? 1 : div;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, restartable so a frame
// can align its sampling grid to the detected start edge.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic restart_i,
    output logic tick_o
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver with 16x oversampling, valid/ready byte output,
// one-cycle frame-error pulse and sticky overrun flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 overrun_clr
);

    localparam int DIV  = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int SC_W = $clog2(OVERSAMPLE);
    localparam int BC_W = $clog2(DATA_BITS);
    localparam logic [SC_W-1:0] SC_MID  = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

    logic                 rx_meta_q, rx_s_q;
    uart_state_e          state_q;
    logic [SC_W-1:0]      sc_q;
    logic [BC_W-1:0]      bc_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 deliver_q;
    logic                 frame_err_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 overrun_q, overrun_d;
    logic                 tick;
    logic                 restart;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign restart = (state_q == ST_IDLE) && !rx_s_q;

    uart_baud_tick #(
        .DIV(DIV)
    ) u_tick (
        .clk      (clk),
        .reset    (reset),
        .restart_i(restart),
        .tick_o   (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sc_q        <= '0;
            bc_q        <= '0;
            shift_q     <= '0;
            deliver_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            deliver_q   <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= ST_START;
                        sc_q    <= '0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (sc_q == SC_MID) begin
                            // A start bit that is already high again at its midpoint is a glitch.
                            if (!rx_s_q) begin
                                state_q <= ST_DATA;
                                sc_q    <= '0;
                                bc_q    <= '0;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            sc_q <= sc_q + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (sc_q == SC_LAST) begin
                            sc_q    <= '0;
                            shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                            if (bc_q == BC_LAST) begin
                                state_q <= ST_STOP;
                            end else begin
                                bc_q <= bc_q + 1'b1;
                            end
                        end else begin
                            sc_q <= sc_q + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (sc_q == SC_LAST) begin
                            sc_q <= '0;
                            if (rx_s_q) begin
                                deliver_q <= 1'b1;
                                state_q   <= ST_IDLE;
                            end else begin
                                frame_err_q <= 1'b1;
                                state_q     <= ST_BREAK;
                            end
                        end else begin
                            sc_q <= sc_q + 1'b1;
                        end
                    end
                end
                ST_BREAK: begin
                    if (rx_s_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A completed frame that finds the previous byte still unconsumed sets overrun; set beats clear.
    always_comb begin
        overrun_d = overrun_q;
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (deliver_q && valid_q && !ready) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
            if (deliver_q && (!valid_q || ready)) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
            end else if (valid_q && ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serialises frames onto rx, scoreboards delivered bytes and checks flags.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BIT_CLKS = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic       overrun_clr = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    int vectors = 0;
    int miscompares = 0;
    int hs_count = 0;
    int fe_count = 0;
    int valid_cycles = 0;
    logic [7:0] exp_q[$];

    uart_rx #(
        .CLK_FREQ  (1_600_000),
        .BAUD_RATE (100_000),
        .OVERSAMPLE(16),
        .DATA_BITS (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    // Handshake monitor: every accepted byte is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (!reset) begin
            if (valid) valid_cycles++;
            if (frame_err) fe_count++;
            if (valid && ready) begin
                logic [7:0] e;
                vectors++;
                hs_count++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rx_byte: got 0x%02h, required no byte", data);
                end else begin
                    e = exp_q.pop_front();
                    if (data !== e) begin
                        miscompares++;
                        $display("FAIL rx_byte: got 0x%02h, required 0x%02h", data, e);
                    end else begin
                        $display("rx byte 0x%02h ok", data);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        tick(BIT_CLKS);
    endtask

    // Leaves rx at the stop-bit level on return.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
    endtask

    task automatic check_int(input string name, input int got, input int req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(3);
        check_int("reset_valid", int'(valid), 0);
        check_int("reset_data", int'(data), 0);
        check_int("reset_frame_err", int'(frame_err), 0);
        check_int("reset_overrun", int'(overrun), 0);
        reset = 1'b0;
        tick(2);
        $display("test_reset done");
    endtask

    task automatic test_single;
        int h0, f0, v0;
        h0 = hs_count; f0 = fe_count; v0 = valid_cycles;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        tick(4);
        check_int("single_handshakes", hs_count - h0, 1);
        check_int("single_valid_cycles", valid_cycles - v0, 1);
        check_int("single_frame_err", fe_count - f0, 0);
        check_int("single_overrun", int'(overrun), 0);
        $display("test_single done");
    endtask

    task automatic test_back_to_back;
        int h0;
        logic [7:0] frames [3];
        frames[0] = 8'h00; frames[1] = 8'hFF; frames[2] = 8'h3C;
        h0 = hs_count;
        for (int i = 0; i < 3; i++) exp_q.push_back(frames[i]);
        for (int i = 0; i < 3; i++) send_frame(frames[i], 1'b1);
        tick(4);
        check_int("b2b_handshakes", hs_count - h0, 3);
        check_int("b2b_pending", exp_q.size(), 0);
        $display("test_back_to_back done");
    endtask

    task automatic test_glitch;
        int h0, f0;
        h0 = hs_count; f0 = fe_count;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(40);
        check_int("glitch_handshakes", hs_count - h0, 0);
        check_int("glitch_frame_err", fe_count - f0, 0);
        check_int("glitch_state_idle", int'(dut.state_q == ST_IDLE), 1);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        tick(4);
        check_int("glitch_next_frame", hs_count - h0, 1);
        $display("test_glitch done");
    endtask

    task automatic test_frame_err;
        int h0, f0;
        h0 = hs_count; f0 = fe_count;
        send_frame(8'h81, 1'b0);
        tick(3 * BIT_CLKS);
        rx = 1'b1;
        tick(20);
        check_int("ferr_pulses", fe_count - f0, 1);
        check_int("ferr_handshakes", hs_count - h0, 0);
        check_int("ferr_state_idle", int'(dut.state_q == ST_IDLE), 1);
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1);
        tick(4);
        check_int("ferr_next_frame", hs_count - h0, 1);
        $display("test_frame_err done");
    endtask

    task automatic test_overrun;
        int h0;
        h0 = hs_count;
        ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        tick(2);
        check_int("ovr_first_valid", int'(valid), 1);
        check_int("ovr_first_overrun", int'(overrun), 0);
        send_frame(8'h22, 1'b1);
        tick(4);
        check_int("ovr_held_data", int'(data), 8'h11);
        check_int("ovr_held_valid", int'(valid), 1);
        check_int("ovr_flag_set", int'(overrun), 1);
        ready = 1'b1;
        tick(2);
        check_int("ovr_handshakes", hs_count - h0, 1);
        check_int("ovr_valid_drop", int'(valid), 0);
        check_int("ovr_sticky", int'(overrun), 1);
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        check_int("ovr_cleared", int'(overrun), 0);
        $display("test_overrun done");
    endtask

    task automatic test_reset_mid;
        int h0;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        rx = 1'b1;
        reset = 1'b1;
        tick(1);
        check_int("rmid_data", int'(data), 0);
        check_int("rmid_valid", int'(valid), 0);
        check_int("rmid_frame_err", int'(frame_err), 0);
        check_int("rmid_overrun", int'(overrun), 0);
        reset = 1'b0;
        tick(4);
        h0 = hs_count;
        exp_q.push_back(8'h99);
        send_frame(8'h99, 1'b1);
        tick(4);
        check_int("rmid_next_frame", hs_count - h0, 1);
        check_int("rmid_pending", exp_q.size(), 0);
        $display("test_reset_mid done");
    endtask

    initial begin
        tick(1);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_mid();
        tick(4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
